// File: rtl/sample_buf_pkg.sv
// Shared parameters, readout FSM states and pointer helpers for the
// sample buffer reader. Optional macro READOUT_CHECKSUM_EN adds the CHECK state.
package sample_buf_pkg;

  localparam int NUM_CHANNELS = 14;
  localparam int SAMPLE_WIDTH = 8;
  localparam int DEPTH        = 10;
  localparam int CW           = 4;
  localparam int CNTW         = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA
`ifdef READOUT_CHECKSUM_EN
    , ST_CHECK
`endif
  } state_t;

  // Header byte: sample count in the high nibble, channel in the low nibble.
  function automatic logic [SAMPLE_WIDTH-1:0] pack_header(input logic [CNTW-1:0] n,
                                                          input logic [CW-1:0]   ch);
    return {n, ch};
  endfunction

  function automatic logic [CNTW-1:0] ptr_inc(input logic [CNTW-1:0] p);
    return (p == CNTW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // (w - n) mod DEPTH; 4-bit wraparound is harmless because the true result is < DEPTH.
  function automatic logic [CNTW-1:0] ptr_sub(input logic [CNTW-1:0] w,
                                              input logic [CNTW-1:0] n);
    logic [CNTW-1:0] d;
    if (w >= n) d = w - n;
    else        d = w + CNTW'(DEPTH) - n;
    return d;
  endfunction

endpackage

// File: rtl/sample_buffer_reader_ring.sv
// Per-channel ring bookkeeping: write pointer and saturating fill count,
// cleared when a readout drains the channel.
module sample_ring_ctrl
  import sample_buf_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            clr,
  output logic [CNTW-1:0] wptr,
  output logic [CNTW-1:0] count
);

  // Advance the write pointer and fill count on each committed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= ptr_inc(wptr);
      if (clr)
        count <= '0;
      else if (wr_en && count != CNTW'(DEPTH))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sample_buffer_reader.sv
// Per-channel sample ring buffers with a framed header+data readout engine.
// Optional macro READOUT_CHECKSUM_EN appends an XOR checksum byte to each frame.
module sample_buffer_reader
  import sample_buf_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    wr_valid,
  input  logic [CW-1:0]           wr_chan,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    rd_req,
  input  logic [CW-1:0]           rd_chan,
  output logic                    rd_busy,
  output logic [SAMPLE_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam logic [CW-1:0] NUM_CH_L = CW'(NUM_CHANNELS);

  logic [SAMPLE_WIDTH-1:0] mem [NUM_CHANNELS][DEPTH];
  logic [CNTW-1:0]         wptr  [NUM_CHANNELS];
  logic [CNTW-1:0]         count [NUM_CHANNELS];

  state_t          state, state_next;
  logic [CW-1:0]   active_chan;
  logic [CNTW-1:0] rptr;
  logic [CNTW-1:0] remaining;
  logic [CNTW-1:0] sel_count, sel_wptr, wr_wptr;
  logic            accept, hs, drain, wr_commit;
`ifdef READOUT_CHECKSUM_EN
  logic [SAMPLE_WIDTH-1:0] csum;
`endif

  assign rd_busy   = (state != ST_IDLE);
  assign out_valid = (state != ST_IDLE);
  assign wr_ready  = !(rd_busy && wr_chan == active_chan);
  assign hs        = out_valid && out_ready;
  assign accept    = (state == ST_IDLE) && rd_req && ena && (rd_chan < NUM_CH_L);
  assign wr_commit = wr_valid && wr_ready && ena && (wr_chan < NUM_CH_L);
  assign drain     = (state == ST_DATA) && hs && (remaining == CNTW'(1));

  // Select ring state for the requested read channel and the write channel.
  always_comb begin
    sel_count = '0;
    sel_wptr  = '0;
    wr_wptr   = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_chan == CW'(i)) begin
        sel_count = count[i];
        sel_wptr  = wptr[i];
      end
      if (wr_chan == CW'(i)) wr_wptr = wptr[i];
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ring
    sample_ring_ctrl u_ring (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_commit && wr_chan == CW'(g)),
      .clr   (drain && active_chan == CW'(g)),
      .wptr  (wptr[g]),
      .count (count[g])
    );
  end

  // Sample storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[wr_chan][wr_wptr] <= wr_data;
  end

  // Readout state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Readout next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_HEADER;
      ST_HEADER: begin
        if (hs) begin
          if (remaining != '0) state_next = ST_DATA;
`ifdef READOUT_CHECKSUM_EN
          else                 state_next = ST_CHECK;
`else
          else                 state_next = ST_IDLE;
`endif
        end
      end
      ST_DATA: begin
`ifdef READOUT_CHECKSUM_EN
        if (drain) state_next = ST_CHECK;
`else
        if (drain) state_next = ST_IDLE;
`endif
      end
`ifdef READOUT_CHECKSUM_EN
      ST_CHECK:  if (hs) state_next = ST_IDLE;
`endif
      default:   state_next = ST_IDLE;
    endcase
  end

  // Snapshot on acceptance and registered output byte; each byte is loaded
  // one cycle ahead so out_data/out_last change only on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_chan <= '0;
      rptr        <= '0;
      remaining   <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            active_chan <= rd_chan;
            remaining   <= sel_count;
            rptr        <= ptr_sub(sel_wptr, sel_count);
            out_data    <= pack_header(sel_count, rd_chan);
`ifdef READOUT_CHECKSUM_EN
            out_last    <= 1'b0;
            csum        <= pack_header(sel_count, rd_chan);
`else
            out_last    <= (sel_count == '0);
`endif
          end
        end
        ST_HEADER: begin
          if (hs) begin
            if (remaining != '0) begin
              out_data <= mem[active_chan][rptr];
`ifdef READOUT_CHECKSUM_EN
              out_last <= 1'b0;
`else
              out_last <= (remaining == CNTW'(1));
`endif
            end else begin
`ifdef READOUT_CHECKSUM_EN
              out_data <= csum;
              out_last <= 1'b1;
`else
              out_last <= 1'b0;
`endif
            end
          end
        end
        ST_DATA: begin
          if (hs) begin
`ifdef READOUT_CHECKSUM_EN
            csum <= csum ^ out_data;
`endif
            if (remaining == CNTW'(1)) begin
`ifdef READOUT_CHECKSUM_EN
              out_data <= csum ^ out_data;
              out_last <= 1'b1;
`else
              out_last <= 1'b0;
`endif
            end else begin
              rptr      <= ptr_inc(rptr);
              remaining <= remaining - 1'b1;
              out_data  <= mem[active_chan][ptr_inc(rptr)];
`ifdef READOUT_CHECKSUM_EN
              out_last  <= 1'b0;
`else
              out_last  <= (remaining == CNTW'(2));
`endif
            end
          end
        end
`ifdef READOUT_CHECKSUM_EN
        ST_CHECK: if (hs) out_last <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Self-checking bench for sample_buffer_reader: cycle table plus frame sequences.
module tb_sample_buffer_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_chan = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       rd_req = 1'b0;
  logic [3:0] rd_chan = '0;
  logic       rd_busy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;

  int n_checks = 0;
  int n_fail   = 0;

  sample_buffer_reader dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .wr_valid(wr_valid), .wr_chan(wr_chan), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_chan(rd_chan), .rd_busy(rd_busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [3:0] wc;
    logic [7:0] wd;
    logic       rr;
    logic [3:0] rc;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       eb;
    logic       ewr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic add(input logic wv, input logic [3:0] wc, input logic [7:0] wd,
                     input logic rr, input logic [3:0] rc, input logic ordy,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic eb, input logic ewr);
    vec_t v;
    v.wv = wv; v.wc = wc; v.wd = wd; v.rr = rr; v.rc = rc; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.ewr = ewr;
    vecs.push_back(v);
  endtask

  task automatic write_sample(input logic [3:0] ch, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_chan = ch; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_chan = '0;
  endtask

  task automatic start_read(input logic [3:0] ch);
    @(negedge clk);
    rd_req = 1'b1; rd_chan = ch; out_ready = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  // Drains one frame, checking bytes against exp_q (plus checksum when enabled).
  task automatic collect(input string name, input bit toggle);
    logic [7:0] q[$];
    logic [7:0] held_d;
    logic       held_l;
    logic [7:0] x;
    bit         rdy, stalled;
    int         idx, cyc;
    q = exp_q;
`ifdef READOUT_CHECKSUM_EN
    x = '0;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`endif
    idx = 0; cyc = 0; rdy = 1'b1; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (idx < q.size() && cyc < 200) begin
      @(negedge clk);
      out_ready = toggle ? rdy : 1'b1;
      #1;
      if (stalled) begin
        chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_hold_data"},  32'(out_data),  32'(held_d));
        chk({name, "_hold_last"},  32'(out_last),  32'(held_l));
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk($sformatf("%s_byte%0d", name, idx), 32'(out_data), 32'(q[idx]));
          chk($sformatf("%s_last%0d", name, idx), 32'(out_last), 32'(idx == q.size() - 1));
          idx++;
        end else begin
          stalled = 1'b1; held_d = out_data; held_l = out_last;
        end
      end
      rdy = !rdy;
      cyc++;
    end
    if (idx < q.size()) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got %0d bytes expected %0d", name, idx, q.size());
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk({name, "_end_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_end_busy"},  32'(rd_busy),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(rd_busy),   32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_wrrdy", 32'(wr_ready),  32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Cycle table: three writes to ch5, read, then re-read after drain
    add(1, 5, 8'h11, 0, 0, 0,  0, 8'h00, 0, 0, 1);
    add(1, 5, 8'h22, 0, 0, 0,  0, 8'h00, 0, 0, 1);
    add(1, 5, 8'h33, 0, 0, 0,  0, 8'h00, 0, 0, 1);
    add(0, 0, 8'h00, 1, 5, 1,  0, 8'h00, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1,  1, 8'h35, 0, 1, 1);
    add(0, 5, 8'h00, 0, 0, 1,  1, 8'h11, 0, 1, 0);
    add(0, 8, 8'h00, 0, 0, 1,  1, 8'h22, 0, 1, 1);
`ifdef READOUT_CHECKSUM_EN
    add(0, 0, 8'h00, 0, 0, 1,  1, 8'h33, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 1,  1, 8'h35, 1, 1, 1);
    add(0, 0, 8'h00, 1, 5, 1,  0, 8'h00, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1,  1, 8'h05, 0, 1, 1);
    add(0, 0, 8'h00, 0, 0, 1,  1, 8'h05, 1, 1, 1);
`else
    add(0, 0, 8'h00, 0, 0, 1,  1, 8'h33, 1, 1, 1);
    add(0, 0, 8'h00, 1, 5, 1,  0, 8'h00, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1,  1, 8'h05, 1, 1, 1);
`endif
    add(0, 0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr_valid = vecs[i].wv; wr_chan = vecs[i].wc; wr_data = vecs[i].wd;
      rd_req = vecs[i].rr; rd_chan = vecs[i].rc; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_busy", i),  32'(rd_busy),   32'(vecs[i].eb));
      chk($sformatf("vec%0d_wrrdy", i), 32'(wr_ready),  32'(vecs[i].ewr));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
        chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(vecs[i].el));
      end
    end
    @(negedge clk);
    wr_valid = 1'b0; rd_req = 1'b0; wr_chan = '0;

    // Wrap: 12 writes into a depth-10 ring, ena dropped mid-frame
    for (int i = 1; i <= 12; i++) write_sample(4'd0, 8'(i));
    start_read(4'd0);
    ena = 1'b0;
    exp_q = {8'hA0, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    collect("wrap", 1'b0);
    ena = 1'b1;

    // Back-pressure with out_ready toggling
    for (int i = 0; i < 4; i++) write_sample(4'd2, 8'hA1 + 8'(i));
    start_read(4'd2);
    exp_q = {8'h42, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    collect("stall", 1'b1);

    // Writes during a readout: active channel blocked, others accepted
    write_sample(4'd7, 8'h70);
    write_sample(4'd7, 8'h71);
    write_sample(4'd8, 8'h80);
    start_read(4'd7);
    @(negedge clk);
    wr_valid = 1'b1; wr_chan = 4'd7; wr_data = 8'h7F; #1;
    chk("busy_wrrdy_ch7", 32'(wr_ready), 32'd0);
    chk("busy_hdr_ch7",   32'(out_data), 32'h27);
    @(negedge clk);
    wr_chan = 4'd8; wr_data = 8'h81; #1;
    chk("busy_wrrdy_ch8", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_chan = '0;
    exp_q = {8'h27, 8'h70, 8'h71};
    collect("ch7", 1'b0);
    start_read(4'd8);
    exp_q = {8'h28, 8'h80, 8'h81};
    collect("ch8", 1'b0);
    start_read(4'd7);
    exp_q = {8'h07};
    collect("ch7_drained", 1'b0);

    // Same-cycle write and request on one channel: snapshot excludes the write
    write_sample(4'd9, 8'h90);
    @(negedge clk);
    wr_valid = 1'b1; wr_chan = 4'd9; wr_data = 8'h91;
    rd_req = 1'b1; rd_chan = 4'd9; out_ready = 1'b0;
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_req = 1'b0; wr_chan = '0;
    exp_q = {8'h19, 8'h90};
    collect("simul", 1'b0);

    // Rejected requests and dropped writes
    @(negedge clk);
    rd_req = 1'b1; rd_chan = 4'd14;
    @(posedge clk); #1; rd_req = 1'b0;
    @(negedge clk); #1;
    chk("badch_valid", 32'(out_valid), 32'd0);
    chk("badch_busy",  32'(rd_busy),   32'd0);
    write_sample(4'd15, 8'hEE);
    ena = 1'b0;
    write_sample(4'd3, 8'h33);
    @(negedge clk);
    rd_req = 1'b1; rd_chan = 4'd3;
    @(posedge clk); #1; rd_req = 1'b0;
    @(negedge clk); #1;
    chk("ena0_valid", 32'(out_valid), 32'd0);
    ena = 1'b1;
    start_read(4'd3);
    exp_q = {8'h03};
    collect("ch3_empty", 1'b0);

    // Checksum frame (plain header+data when the checksum is disabled)
    write_sample(4'd1, 8'hF0);
    write_sample(4'd1, 8'h0F);
    start_read(4'd1);
    exp_q = {8'h21, 8'hF0, 8'h0F};
    collect("ch1", 1'b0);

    // Asynchronous reset in the middle of DATA
    write_sample(4'd4, 8'h41);
    write_sample(4'd4, 8'h42);
    write_sample(4'd4, 8'h43);
    write_sample(4'd6, 8'h61);
    start_read(4'd4);
    @(negedge clk); out_ready = 1'b1; #1;
    chk("mid_hdr", 32'(out_data), 32'h34);
    @(negedge clk); #1;
    chk("mid_d0", 32'(out_data), 32'h41);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy",  32'(rd_busy),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    start_read(4'd4);
    exp_q = {8'h04};
    collect("post_rst_ch4", 1'b0);
    start_read(4'd6);
    exp_q = {8'h06};
    collect("post_rst_ch6", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
